// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch program-counter unit.
//   FETCH_PC_WIDTH     : default width of the PC and every address port
//   FETCH_RESET_VECTOR : PC value after reset
//   SEL_*              : bit positions inside the one-hot load select
//   load_src_e         : decoded load source used by the select mux
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned FETCH_PC_WIDTH = 14;
  localparam logic [FETCH_PC_WIDTH-1:0] FETCH_RESET_VECTOR = 14'h0000;

  localparam int unsigned SEL_SEQ    = 0;
  localparam int unsigned SEL_BRANCH = 1;
  localparam int unsigned SEL_INT    = 2;
  localparam int unsigned SEL_RET    = 3;

  typedef enum logic [1:0] {
    LOAD_SEQ    = 2'd0,
    LOAD_BRANCH = 2'd1,
    LOAD_INT    = 2'd2,
    LOAD_RET    = 2'd3
  } load_src_e;

endpackage : fetch_pkg

// File: rtl/fetch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_if
// Bundles the hazard-unit / IF-ID side signals of the PC unit.
//   stall                    : 1 = hold PC this cycle
//   prog_cntr_input_sel[3:0] : one-hot load select (seq/branch/int/ret)
//   branch_target_address    : branch/jump target
//   interrupt_branch_addr    : interrupt vector
//   ret_addr_mem             : return address popped from memory/stack
//   prog_mem_fetch_read_addr : current PC (program memory read address)
//   ret_addr_out             : PC + 1, return address to save
// master = the side driving select/addresses, slave = the PC unit.
// -----------------------------------------------------------------------------
interface fetch_pc_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = FETCH_PC_WIDTH
);
  logic                stall;
  logic [3:0]          prog_cntr_input_sel;
  logic [PC_WIDTH-1:0] branch_target_address;
  logic [PC_WIDTH-1:0] interrupt_branch_addr;
  logic [PC_WIDTH-1:0] ret_addr_mem;
  logic [PC_WIDTH-1:0] prog_mem_fetch_read_addr;
  logic [PC_WIDTH-1:0] ret_addr_out;

  modport master (
    output stall, prog_cntr_input_sel, branch_target_address,
           interrupt_branch_addr, ret_addr_mem,
    input  prog_mem_fetch_read_addr, ret_addr_out
  );

  modport slave (
    input  stall, prog_cntr_input_sel, branch_target_address,
           interrupt_branch_addr, ret_addr_mem,
    output prog_mem_fetch_read_addr, ret_addr_out
  );
endinterface : fetch_pc_unit_if

// File: rtl/fetch_pc_unit_load_sel_mux.sv
// -----------------------------------------------------------------------------
// pc_load_sel_mux
// Purely combinational priority mux choosing the next PC load value.
//   sel_i      : one-hot load select (SEL_* bit positions)
//   next_pc_i  : PC + 1
//   branch_i   : branch target
//   intr_i     : interrupt vector (used only with FETCH_INTERRUPT_EN)
//   ret_i      : return address
//   load_o     : selected load value
// Priority: interrupt > return > branch > sequential. Any other select
// pattern (including 4'b0000) falls through to sequential.
// Build option: FETCH_INTERRUPT_EN enables the interrupt candidate; when it
// is undefined the interrupt select bit and vector are ignored.
// -----------------------------------------------------------------------------
module pc_load_sel_mux
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = FETCH_PC_WIDTH
) (
  input  logic [3:0]          sel_i,
  input  logic [PC_WIDTH-1:0] next_pc_i,
  input  logic [PC_WIDTH-1:0] branch_i,
  input  logic [PC_WIDTH-1:0] intr_i,
  input  logic [PC_WIDTH-1:0] ret_i,
  output logic [PC_WIDTH-1:0] load_o
);

  load_src_e src_s;

`ifdef FETCH_INTERRUPT_EN
  // Sequential is the fall-through, so its select bit carries no information.
  logic unused_sel_s;
  assign unused_sel_s = sel_i[SEL_SEQ];

  // Resolve the select bits into a single load source by fixed priority.
  always_comb begin
    src_s = LOAD_SEQ;
    if (sel_i[SEL_INT] == 1'b1) begin
      src_s = LOAD_INT;
    end else if (sel_i[SEL_RET] == 1'b1) begin
      src_s = LOAD_RET;
    end else if (sel_i[SEL_BRANCH] == 1'b1) begin
      src_s = LOAD_BRANCH;
    end else begin
      src_s = LOAD_SEQ;
    end
  end
`else
  // Interrupt bit and vector have no load here; sequential bit is fall-through.
  logic unused_sel_s;
  assign unused_sel_s = sel_i[SEL_SEQ] ^ sel_i[SEL_INT] ^ (^intr_i);

  // Resolve the select bits into a single load source by fixed priority.
  always_comb begin
    src_s = LOAD_SEQ;
    if (sel_i[SEL_RET] == 1'b1) begin
      src_s = LOAD_RET;
    end else if (sel_i[SEL_BRANCH] == 1'b1) begin
      src_s = LOAD_BRANCH;
    end else begin
      src_s = LOAD_SEQ;
    end
  end
`endif

  // Route the chosen candidate to the load output.
  always_comb begin
    load_o = next_pc_i;
    case (src_s)
      LOAD_SEQ:    load_o = next_pc_i;
      LOAD_BRANCH: load_o = branch_i;
`ifdef FETCH_INTERRUPT_EN
      LOAD_INT:    load_o = intr_i;
`endif
      LOAD_RET:    load_o = ret_i;
      default:     load_o = next_pc_i;
    endcase
  end

endmodule : pc_load_sel_mux

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Program-counter register of the fetch stage.
//   clock  : single clock, rising-edge
//   nreset : synchronous reset, ACTIVE HIGH despite the name
//   pc_if  : slave side of fetch_pc_unit_if (stall, select, redirect
//            addresses in; fetch address and return address out)
// The PC register drives the fetch address directly. ret_addr_out is PC + 1
// derived only from the register. Reset beats stall, stall beats any select.
// Build option: FETCH_INTERRUPT_EN (see pc_load_sel_mux).
// -----------------------------------------------------------------------------
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = FETCH_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = FETCH_RESET_VECTOR
) (
  input  logic           clock,
  input  logic           nreset,
  fetch_pc_unit_if.slave pc_if
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] next_pc_s;
  logic [PC_WIDTH-1:0] load_s;

  // Wraps naturally at 2^PC_WIDTH.
  assign next_pc_s = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  pc_load_sel_mux #(
    .PC_WIDTH (PC_WIDTH)
  ) u_load_sel (
    .sel_i     (pc_if.prog_cntr_input_sel),
    .next_pc_i (next_pc_s),
    .branch_i  (pc_if.branch_target_address),
    .intr_i    (pc_if.interrupt_branch_addr),
    .ret_i     (pc_if.ret_addr_mem),
    .load_o    (load_s)
  );

  // Stall holds the PC and drops whatever redirect is being presented.
  always_comb begin
    pc_d = pc_q;
    if (pc_if.stall == 1'b1) begin
      pc_d = pc_q;
    end else begin
      pc_d = load_s;
    end
  end

  // PC register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (nreset == 1'b1) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_if.prog_mem_fetch_read_addr = pc_q;
  assign pc_if.ret_addr_out             = next_pc_s;

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Self-checking bench: directed vector table, a hand-written stall sequence,
// then randomized stimulus against an arithmetic reference model.
// Honours FETCH_INTERRUPT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

  localparam int unsigned W = 14;

  logic clock;
  logic nreset;
  int   n_cmp;
  int   n_err;

  fetch_pc_unit_if #(.PC_WIDTH(W)) pc_if ();

  fetch_pc_unit #(
    .PC_WIDTH     (W),
    .RESET_VECTOR (14'h0000)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .pc_if  (pc_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef FETCH_INTERRUPT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       stall;
    logic [3:0] sel;
    logic [13:0] br;
    logic [13:0] intr;
    logic [13:0] ret;
    logic [13:0] exp_pc;
    logic [13:0] exp_ret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic stall, logic [3:0] sel,
                              logic [13:0] br, logic [13:0] intr,
                              logic [13:0] ret, logic [13:0] exp_pc,
                              logic [13:0] exp_ret);
    vec_t v;
    v.rst = rst; v.stall = stall; v.sel = sel;
    v.br = br; v.intr = intr; v.ret = ret;
    v.exp_pc = exp_pc; v.exp_ret = exp_ret;
    return v;
  endfunction

  task automatic check(input string name, input logic [13:0] act,
                       input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, sample 1 ns after the edge.
  task automatic step(input logic rst, input logic stall, input logic [3:0] sel,
                      input logic [13:0] br, input logic [13:0] intr,
                      input logic [13:0] ret);
    nreset                      = rst;
    pc_if.stall                 = stall;
    pc_if.prog_cntr_input_sel   = sel;
    pc_if.branch_target_address = br;
    pc_if.interrupt_branch_addr = intr;
    pc_if.ret_addr_mem          = ret;
    @(posedge clock);
    #1;
  endtask

  // Reference: the spec's rules in plain integer arithmetic.
  function automatic int ref_next(int pc, bit rst, bit stall, logic [3:0] sel,
                                  int br, int intr, int ret);
    if (rst) return 0;
    if (stall) return pc;
    if (INT_EN && sel[2]) return intr;
    if (sel[3]) return ret;
    if (sel[1]) return br;
    return (pc + 1) % 16384;
  endfunction

  logic [13:0] exp_pri;
  logic [13:0] exp_all;
  logic [13:0] exp_int_only;
  int          mdl_pc;

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_pri      = INT_EN ? 14'h0100 : 14'h0200;
    exp_all      = INT_EN ? 14'h0155 : 14'h0777;
    exp_int_only = INT_EN ? 14'h0155 : 14'h0124;

    //             rst   stl   sel      br       intr     ret      pc       ret_out
    vecs.push_back(mk(1'b1, 1'b1, 4'b0010, 14'h1234, 14'h0000, 14'h0000, 14'h0000, 14'h0001));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0010, 14'h1234, 14'h0000, 14'h0000, 14'h0000, 14'h0001));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 14'h0000, 14'h0000, 14'h0000, 14'h0001, 14'h0002));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 14'h0000, 14'h0000, 14'h0000, 14'h0002, 14'h0003));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 14'h0000, 14'h0000, 14'h0000, 14'h0003, 14'h0004));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 14'h0000, 14'h0000, 14'h0000, 14'h0004, 14'h0005));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 14'h0000, 14'h0000, 14'h0000, 14'h0005, 14'h0006));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0010, 14'h3FFF, 14'h0000, 14'h0000, 14'h3FFF, 14'h0000));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0001));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0010, 14'h1234, 14'h0000, 14'h0000, 14'h1234, 14'h1235));
    vecs.push_back(mk(1'b0, 1'b0, 4'b1000, 14'h0000, 14'h0000, 14'h0042, 14'h0042, 14'h0043));
    vecs.push_back(mk(1'b0, 1'b0, 4'b1110, 14'h0300, 14'h0100, 14'h0200, exp_pri, exp_pri + 14'h0001));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0010, 14'h0010, 14'h0000, 14'h0000, 14'h0010, 14'h0011));
    vecs.push_back(mk(1'b0, 1'b1, 4'b0010, 14'h0ABC, 14'h0000, 14'h0000, 14'h0010, 14'h0011));
    vecs.push_back(mk(1'b0, 1'b1, 4'b0010, 14'h0ABC, 14'h0000, 14'h0000, 14'h0010, 14'h0011));
    vecs.push_back(mk(1'b0, 1'b1, 4'b0010, 14'h0ABC, 14'h0000, 14'h0000, 14'h0010, 14'h0011));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0010, 14'h0ABC, 14'h0000, 14'h0000, 14'h0ABC, 14'h0ABD));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0010, 14'h2000, 14'h0000, 14'h0000, 14'h2000, 14'h2001));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0100, 14'h0000, 14'h0100, 14'h0000, 14'h0000, 14'h0001));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0001, 14'h0000, 14'h0000, 14'h0000, 14'h0001, 14'h0002));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 14'h0555, 14'h0666, 14'h0777, 14'h0002, 14'h0003));
    vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 14'h0999, 14'h0155, 14'h0777, exp_all, exp_all + 14'h0001));
    vecs.push_back(mk(1'b0, 1'b0, 4'b1010, 14'h0888, 14'h0000, 14'h0666, 14'h0666, 14'h0667));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0011, 14'h0123, 14'h0000, 14'h0000, 14'h0123, 14'h0124));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0101, 14'h0000, 14'h0155, 14'h0000, exp_int_only, exp_int_only + 14'h0001));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].sel,
           vecs[i].br, vecs[i].intr, vecs[i].ret);
      check($sformatf("vec%0d_pc", i), pc_if.prog_mem_fetch_read_addr, vecs[i].exp_pc);
      check($sformatf("vec%0d_ret", i), pc_if.ret_addr_out, vecs[i].exp_ret);
    end

    // Stall held across an interrupt/return request, then released.
    step(1'b0, 1'b0, 4'b0010, 14'h0050, 14'h0000, 14'h0000);
    check("seq_setup", pc_if.prog_mem_fetch_read_addr, 14'h0050);
    step(1'b0, 1'b1, 4'b1100, 14'h0000, 14'h0444, 14'h0333);
    check("seq_stall1", pc_if.prog_mem_fetch_read_addr, 14'h0050);
    step(1'b0, 1'b1, 4'b1100, 14'h0000, 14'h0444, 14'h0333);
    check("seq_stall2", pc_if.prog_mem_fetch_read_addr, 14'h0050);
    step(1'b0, 1'b0, 4'b1100, 14'h0000, 14'h0444, 14'h0333);
    check("seq_release", pc_if.prog_mem_fetch_read_addr, INT_EN ? 14'h0444 : 14'h0333);
    step(1'b0, 1'b1, 4'b0001, 14'h0000, 14'h0000, 14'h0000);
    check("seq_stall_seq", pc_if.prog_mem_fetch_read_addr, INT_EN ? 14'h0444 : 14'h0333);
    step(1'b0, 1'b0, 4'b0001, 14'h0000, 14'h0000, 14'h0000);
    check("seq_resume", pc_if.prog_mem_fetch_read_addr, INT_EN ? 14'h0445 : 14'h0334);

    // Randomized phase against the reference model.
    mdl_pc = int'(pc_if.prog_mem_fetch_read_addr);
    mdl_pc = INT_EN ? 32'h0445 : 32'h0334;
    for (int k = 0; k < 400; k++) begin
      logic        r_rst;
      logic        r_stall;
      logic [3:0]  r_sel;
      logic [13:0] r_br;
      logic [13:0] r_int;
      logic [13:0] r_ret;
      r_rst   = ($urandom_range(31, 0) == 0);
      r_stall = ($urandom_range(3, 0) == 0);
      r_sel   = 4'($urandom_range(15, 0));
      r_br    = 14'($urandom);
      r_int   = 14'($urandom);
      r_ret   = 14'($urandom);
      if ((k % 50) == 7) begin
        r_br  = 14'h3FFF;
        r_sel = 4'b0010;
      end
      mdl_pc = ref_next(mdl_pc, r_rst, r_stall, r_sel,
                        int'(r_br), int'(r_int), int'(r_ret));
      step(r_rst, r_stall, r_sel, r_br, r_int, r_ret);
      check($sformatf("rnd%0d_pc", k), pc_if.prog_mem_fetch_read_addr, 14'(mdl_pc));
      check($sformatf("rnd%0d_ret", k), pc_if.ret_addr_out, 14'((mdl_pc + 1) % 16384));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_pc_unit
